// File: rtl/motores_pwm_if.sv
// motores_pwm_if: command/status bundle between the control registers and the PWM H-bridge driver.
// Signals: movimiento/duty/duracion/start (command side), busy/done/IN (status and L298 pins).
// master = command source (CPU regs or bench), slave = motores_pwm.
interface motores_pwm_if #(
  parameter int PWM_BITS = 8,
  parameter int DUR_BITS = 24
);
  logic [2:0]          movimiento;
  logic [PWM_BITS-1:0] duty;
  logic [DUR_BITS-1:0] duracion;
  logic                start;
  logic                busy;
  logic                done;
  logic [3:0]          IN;

  modport master (
    output movimiento, duty, duracion, start,
    input  busy, done, IN
  );

  modport slave (
    input  movimiento, duty, duracion, start,
    output busy, done, IN
  );
endinterface

// File: rtl/motores_pwm.sv
// motores_pwm: PWM H-bridge driver for two DC motors (L298), with timed moves and dead time on reversal.
// Latency: start -> busy after 1 edge, start -> first gated pattern on IN after 2 edges.
// Backpressure: none; a start is always accepted and acted on in the cycle it is sampled.
// Ports: clk, rst (sync, active-high); bus (slave): movimiento, duty, duracion, start -> busy, done, IN[3:0].
// IN[3]=IN1, IN[2]=IN2 (motor A), IN[1]=IN3, IN[0]=IN4 (motor B).
module motores_pwm #(
  parameter int PWM_BITS    = 8,
  parameter int DEAD_CYCLES = 1000,
  parameter int DUR_BITS    = 24
) (
  input logic           clk,
  input logic           rst,
  motores_pwm_if.slave  bus
);

  localparam int DW = $clog2(DEAD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DEAD, RUN} state_t;

  state_t              state_q, state_d;
  logic [3:0]          pat_q, pat_d;
  logic [PWM_BITS-1:0] dty_q, dty_d;
  logic [DUR_BITS-1:0] rem_q, rem_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  // Command waiting for the dead time to finish.
  logic [3:0]          ppat_q, ppat_d;
  logic [PWM_BITS-1:0] pdty_q, pdty_d;
  logic [DUR_BITS-1:0] prem_q, prem_d;
  logic [3:0]          in_q, in_d;
  logic                done_q, done_d;

  logic [3:0]          cmd_pat;
  logic                pwm_on;

  // Movement code to pin pattern; 0 and 5..7 map to coast (PAUSA).
  function automatic logic [3:0] decode(input logic [2:0] mv);
    case (mv)
      3'd1:    return 4'b1001;
      3'd2:    return 4'b0110;
      3'd3:    return 4'b0101;
      3'd4:    return 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

  assign cmd_pat = decode(bus.movimiento);
  // Full-scale duty is forced to a constant high; otherwise the counter never reaches it.
  assign pwm_on  = (dty_q == {PWM_BITS{1'b1}}) || (cnt_q < dty_q);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    dty_d   = dty_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    ppat_d  = ppat_q;
    pdty_d  = pdty_q;
    prem_d  = prem_q;
    done_d  = 1'b0;
    in_d    = ((state_q == RUN) && pwm_on) ? pat_q : 4'b0000;

    case (state_q)
      IDLE: begin
        if (bus.start && (cmd_pat != 4'b0000)) begin
          pat_d   = cmd_pat;
          dty_d   = bus.duty;
          rem_d   = bus.duracion;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        cnt_d = cnt_q + 1'b1;
        // A start outranks expiry: no done pulse when both land together.
        if (bus.start) begin
          if (cmd_pat == 4'b0000) begin
            state_d = IDLE;
          end else if (cmd_pat == pat_q) begin
            dty_d = bus.duty;
            rem_d = bus.duracion;
          end else begin
            ppat_d  = cmd_pat;
            pdty_d  = bus.duty;
            prem_d  = bus.duracion;
            dcnt_d  = DW'(DEAD_CYCLES);
            state_d = DEAD;
          end
        end else if (rem_q == DUR_BITS'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (rem_q != '0) begin
          rem_d = rem_q - 1'b1;
        end
      end

      DEAD: begin
        dcnt_d = dcnt_q - 1'b1;
        if (bus.start && (cmd_pat == 4'b0000)) begin
          state_d = IDLE;
        end else begin
          // A new direction overwrites the pending one without restarting the dead time.
          if (bus.start) begin
            ppat_d = cmd_pat;
            pdty_d = bus.duty;
            prem_d = bus.duracion;
          end
          if (dcnt_q == DW'(1)) begin
            pat_d   = ppat_d;
            dty_d   = pdty_d;
            rem_d   = prem_d;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      dty_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      ppat_q  <= '0;
      pdty_q  <= '0;
      prem_q  <= '0;
      in_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      dty_q   <= dty_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      ppat_q  <= ppat_d;
      pdty_q  <= pdty_d;
      prem_q  <= prem_d;
      in_q    <= in_d;
      done_q  <= done_d;
    end
  end

  assign bus.IN   = in_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

endmodule

// File: tb/tb_motores_pwm.sv
// tb_motores_pwm: scenario tasks for motores_pwm; expected pin/status values per cycle go through a scoreboard queue.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Each task compares IN/busy/done on every cycle of its scenario.
module tb_motores_pwm;

  localparam int PWM_BITS = 8;
  localparam int DEAD     = 4;
  localparam int DUR_BITS = 24;

  localparam logic [3:0] P_AV = 4'b0110;
  localparam logic [3:0] P_RE = 4'b1001;
  localparam logic [3:0] P_GD = 4'b0101;
  localparam logic [3:0] P_GI = 4'b1010;
  localparam logic [3:0] P_0  = 4'b0000;

  typedef struct {
    logic [3:0] in;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  motores_pwm_if #(.PWM_BITS(PWM_BITS), .DUR_BITS(DUR_BITS)) bus ();

  motores_pwm #(
    .PWM_BITS   (PWM_BITS),
    .DEAD_CYCLES(DEAD),
    .DUR_BITS   (DUR_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle start; returns just after the edge that samples it.
  task automatic issue(input logic [2:0] mv, input logic [7:0] dt, input int dur);
    @(negedge clk);
    bus.movimiento = mv;
    bus.duty       = dt;
    bus.duracion   = DUR_BITS'(dur);
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
  endtask

  function automatic logic [3:0] gated(input int c, input int d, input logic [3:0] p);
    return ((d == 255) || ((c % 256) < d)) ? p : P_0;
  endfunction

  function automatic exp_t mk(input logic [3:0] in, input logic busy, input logic done);
    exp_t e;
    e.in = in; e.busy = busy; e.done = done;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    for (int t = 0; t < 4; t++) begin
      if (t == 2) begin
        @(negedge clk);
        rst = 1'b0;
      end
      step();
      sbq.push_back(mk(P_0, 1'b0, 1'b0));
      e = sbq.pop_front();
      total++;
      if ({bus.IN, bus.busy, bus.done} !== {e.in, e.busy, e.done}) begin
        bad++;
        $display("FAIL reset t=%0d got IN=%b busy=%b done=%b want IN=%b busy=%b done=%b",
                 t, bus.IN, bus.busy, bus.done, e.in, e.busy, e.done);
      end
    end
  endtask

  // AVANCE at half duty, untimed: 128 high / 128 low, never done.
  task automatic test_avance();
    exp_t e;
    for (int t = 0; t < 600; t++) begin
      if (t == 0) issue(3'd2, 8'd128, 0);
      else step();
      sbq.push_back(mk((t == 0) ? P_0 : gated(t - 1, 128, P_AV), 1'b1, 1'b0));
      e = sbq.pop_front();
      total++;
      if ({bus.IN, bus.busy, bus.done} !== {e.in, e.busy, e.done}) begin
        bad++;
        $display("FAIL avance t=%0d got IN=%b busy=%b done=%b want IN=%b busy=%b done=%b",
                 t, bus.IN, bus.busy, bus.done, e.in, e.busy, e.done);
      end
    end
  endtask

  // Reset while the pins are driving, then an invalid code (6) from IDLE.
  task automatic test_reset_mid();
    exp_t e;
    for (int t = 0; t < 7; t++) begin
      if (t == 0) begin
        @(negedge clk);
        rst = 1'b1;
        step();
        @(negedge clk);
        rst = 1'b0;
        #1;
      end else if (t == 1) begin
        issue(3'd6, 8'd255, 0);
      end else begin
        step();
      end
      sbq.push_back(mk(P_0, 1'b0, 1'b0));
      e = sbq.pop_front();
      total++;
      if ({bus.IN, bus.busy, bus.done} !== {e.in, e.busy, e.done}) begin
        bad++;
        $display("FAIL reset_mid t=%0d got IN=%b busy=%b done=%b want IN=%b busy=%b done=%b",
                 t, bus.IN, bus.busy, bus.done, e.in, e.busy, e.done);
      end
    end
  endtask

  // RETROCESO full duty for 10 cycles: busy for exactly 10, done on the falling edge of busy.
  task automatic test_timed();
    exp_t e;
    for (int t = 0; t < 15; t++) begin
      if (t == 0) issue(3'd1, 8'd255, 10);
      else step();
      sbq.push_back(mk((t >= 1 && t <= 10) ? P_RE : P_0, t < 10, t == 10));
      e = sbq.pop_front();
      total++;
      if ({bus.IN, bus.busy, bus.done} !== {e.in, e.busy, e.done}) begin
        bad++;
        $display("FAIL timed t=%0d got IN=%b busy=%b done=%b want IN=%b busy=%b done=%b",
                 t, bus.IN, bus.busy, bus.done, e.in, e.busy, e.done);
      end
    end
  endtask

  // AVANCE -> GIROD: 4 coast cycles with busy held, then GIROD; then stop.
  task automatic test_dead();
    exp_t e;
    logic [3:0] want;
    for (int t = 0; t < 19; t++) begin
      if (t == 0) issue(3'd2, 8'd255, 0);
      else if (t == 5) issue(3'd3, 8'd255, 0);
      else if (t == 16) issue(3'd0, 8'd0, 0);
      else step();
      if (t == 0) want = P_0;
      else if (t <= 5) want = P_AV;
      else if (t <= 5 + DEAD) want = P_0;
      else if (t <= 16) want = P_GD;
      else want = P_0;
      sbq.push_back(mk(want, t < 16, 1'b0));
      e = sbq.pop_front();
      total++;
      if ({bus.IN, bus.busy, bus.done} !== {e.in, e.busy, e.done}) begin
        bad++;
        $display("FAIL dead t=%0d got IN=%b busy=%b done=%b want IN=%b busy=%b done=%b",
                 t, bus.IN, bus.busy, bus.done, e.in, e.busy, e.done);
      end
    end
  endtask

  // PAUSA from IDLE is ignored; GIROI then PAUSA stops without done.
  task automatic test_pause();
    exp_t e;
    logic [3:0] want;
    for (int t = 0; t < 13; t++) begin
      if (t == 0) issue(3'd0, 8'd255, 5);
      else if (t == 4) issue(3'd4, 8'd255, 0);
      else if (t == 9) issue(3'd0, 8'd0, 0);
      else step();
      want = (t >= 5 && t <= 9) ? P_GI : P_0;
      sbq.push_back(mk(want, (t >= 4 && t < 9), 1'b0));
      e = sbq.pop_front();
      total++;
      if ({bus.IN, bus.busy, bus.done} !== {e.in, e.busy, e.done}) begin
        bad++;
        $display("FAIL pause t=%0d got IN=%b busy=%b done=%b want IN=%b busy=%b done=%b",
                 t, bus.IN, bus.busy, bus.done, e.in, e.busy, e.done);
      end
    end
  endtask

  // AVANCE duty 64, then AVANCE duty 192 with a 500-cycle duration: no dead time, counter keeps running.
  task automatic test_same_dir();
    localparam int N1 = 300;
    exp_t e;
    logic [3:0] want;
    for (int t = 0; t <= N1 + 505; t++) begin
      if (t == 0) issue(3'd2, 8'd64, 0);
      else if (t == N1) issue(3'd2, 8'd192, 500);
      else step();
      if (t == 0) want = P_0;
      else if (t <= N1 + 500) want = gated(t - 1, (t <= N1) ? 64 : 192, P_AV);
      else want = P_0;
      sbq.push_back(mk(want, t < N1 + 500, t == N1 + 500));
      e = sbq.pop_front();
      total++;
      if ({bus.IN, bus.busy, bus.done} !== {e.in, e.busy, e.done}) begin
        bad++;
        $display("FAIL same_dir t=%0d got IN=%b busy=%b done=%b want IN=%b busy=%b done=%b",
                 t, bus.IN, bus.busy, bus.done, e.in, e.busy, e.done);
      end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.movimiento = 3'd0;
    bus.duty       = '0;
    bus.duracion   = '0;
    test_reset();
    test_avance();
    test_reset_mid();
    test_timed();
    test_dead();
    test_pause();
    test_same_dir();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
